// File: rtl/sad_best_tracker_pkg.sv
// Shared motion-estimation definitions: pixel width, default SAD width,
// search FSM states and the candidate-index width helper.
package me_pkg;

  localparam int PIX_W     = 8;
  localparam int SAD_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of an index over 2*num_pairs candidates.
  function automatic int idx_w_of(input int num_pairs);
    return (num_pairs < 1) ? 1 : $clog2(2 * num_pairs);
  endfunction

endpackage

// File: rtl/sad_best_tracker_accum.sv
// One SAD lane: |c - ref| per accepted pixel, running accumulator that clears
// on the last pixel of a candidate, and a hold register with the finished SAD.
module sad_accum
  import me_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [PIX_W-1:0] i_c,
  input  logic [PIX_W-1:0] i_p,
  output logic [SAD_W-1:0] o_sum,
  output logic [SAD_W-1:0] o_hold
);

  logic signed [PIX_W:0] w_sub;
  logic signed [PIX_W:0] w_neg;
  logic [PIX_W-1:0]      w_diff;
  logic [SAD_W-1:0]      r_acc;
  logic [SAD_W-1:0]      r_hold;

  assign w_sub  = $signed({1'b0, i_c}) - $signed({1'b0, i_p});
  assign w_neg  = -w_sub;
  assign w_diff = w_sub[PIX_W] ? w_neg[PIX_W-1:0] : w_sub[PIX_W-1:0];

  // Sum including the current pixel; this is the candidate SAD on the last pixel.
  assign o_sum  = r_acc + SAD_W'(w_diff);
  assign o_hold = r_hold;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_acc  <= '0;
      r_hold <= '0;
    end else if (i_valid) begin
      if (i_last) begin
        r_hold <= o_sum;
        r_acc  <= '0;
      end else begin
        r_acc <= o_sum;
      end
    end
  end

endmodule

// File: rtl/sad_best_tracker.sv
// Dual-lane SAD accumulation with running-minimum search over 2*NUM_PAIRS
// candidates. Define SAD_CAND_OUT_EN to add the per-candidate trace outputs.
//
// Handshake: a pixel triple is consumed on every clock edge where the tracker
// is in RUN and in_valid is high; there is no back-pressure, so the producer may
// insert gaps of any length but never has to wait.
module sad_best_tracker
  import me_pkg::*;
#(
  parameter int PIX_PER_CAND = 256,
  parameter int NUM_PAIRS    = 8,
  parameter int SAD_W        = SAD_W_DEF,
  parameter int IDX_W        = idx_w_of(NUM_PAIRS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] p,
  input  logic [PIX_W-1:0] p_prime,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
`ifdef SAD_CAND_OUT_EN
  output logic             cand_valid,
  output logic [IDX_W-1:0] cand_idx,
  output logic [SAD_W-1:0] cand_sad,
`endif
  output logic [1:0]       dbg_state
);

  localparam int PIX_CNT_W = $clog2(PIX_PER_CAND);
  localparam int PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [SAD_W-1:0]   r_best_sad;
  logic [IDX_W-1:0]   r_best_idx;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic [PAIR_W-1:0]  r_pair_cnt;
  logic [PAIR_W-1:0]  r_cmp_pair;
  logic               r_pair_rdy;
  logic [SAD_W-1:0]   r_run_min;
  logic [IDX_W-1:0]   r_run_idx;

  logic               w_accept;
  logic               w_last_pix;
  logic               w_last_pair;
  logic [SAD_W-1:0]   w_sum_a;
  logic [SAD_W-1:0]   w_sum_b;
  logic [SAD_W-1:0]   w_hold_a;
  logic [SAD_W-1:0]   w_hold_b;
  logic [IDX_W-1:0]   w_even_idx;
  logic [IDX_W-1:0]   w_odd_idx;
  logic               w_a_lt;
  logic               w_b_lt;
  logic [SAD_W-1:0]   w_min1;
  logic [IDX_W-1:0]   w_idx1;
  logic [SAD_W-1:0]   w_min2;
  logic [IDX_W-1:0]   w_idx2;

  // A start pulse always wins over pixel acceptance: the search restarts cleanly.
  assign w_accept    = (r_state == RUN) && in_valid && !start;
  assign w_last_pix  = (r_pix_cnt == PIX_CNT_W'(PIX_PER_CAND - 1));
  assign w_last_pair = (r_pair_cnt == PAIR_W'(NUM_PAIRS - 1));

  sad_accum #(.SAD_W(SAD_W)) u_accum_a (
    .clk     (clk),
    .reset   (reset),
    .i_clear (start),
    .i_valid (w_accept),
    .i_last  (w_last_pix),
    .i_c     (c),
    .i_p     (p),
    .o_sum   (w_sum_a),
    .o_hold  (w_hold_a)
  );

  sad_accum #(.SAD_W(SAD_W)) u_accum_b (
    .clk     (clk),
    .reset   (reset),
    .i_clear (start),
    .i_valid (w_accept),
    .i_last  (w_last_pix),
    .i_c     (c),
    .i_p     (p_prime),
    .o_sum   (w_sum_b),
    .o_hold  (w_hold_b)
  );

  assign w_even_idx = IDX_W'({r_cmp_pair, 1'b0});
  assign w_odd_idx  = w_even_idx | IDX_W'(1);

  // Even candidate first, then odd against the updated minimum; strict
  // less-than keeps the lower index on ties.
  always_comb begin
    w_a_lt = (w_hold_a < r_run_min);
    w_min1 = w_a_lt ? w_hold_a : r_run_min;
    w_idx1 = w_a_lt ? w_even_idx : r_run_idx;
    w_b_lt = (w_hold_b < w_min1);
    w_min2 = w_b_lt ? w_hold_b : w_min1;
    w_idx2 = w_b_lt ? w_odd_idx : w_idx1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_best_sad <= '0;
      r_best_idx <= '0;
      r_pix_cnt  <= '0;
      r_pair_cnt <= '0;
      r_cmp_pair <= '0;
      r_pair_rdy <= 1'b0;
      r_run_min  <= '0;
      r_run_idx  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_pair_rdy) begin
        r_run_min  <= w_min2;
        r_run_idx  <= w_idx2;
        r_pair_rdy <= 1'b0;
      end
      if (start) begin
        r_state    <= RUN;
        r_busy     <= 1'b1;
        r_pix_cnt  <= '0;
        r_pair_cnt <= '0;
        r_cmp_pair <= '0;
        r_pair_rdy <= 1'b0;
        r_run_min  <= '1;
        r_run_idx  <= '0;
      end else begin
        case (r_state)
          IDLE: ;
          RUN: begin
            if (in_valid) begin
              r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
              if (w_last_pix) begin
                r_pair_rdy <= 1'b1;
                r_cmp_pair <= r_pair_cnt;
                r_pair_cnt <= w_last_pair ? '0 : r_pair_cnt + 1'b1;
                if (w_last_pair) r_state <= FINAL;
              end
            end
          end
          FINAL: begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_best_sad <= w_min2;
            r_best_idx <= w_idx2;
          end
          DONE: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign best_sad  = r_best_sad;
  assign best_idx  = r_best_idx;
  assign dbg_state = r_state;

`ifdef SAD_CAND_OUT_EN
  logic             r_cand_valid;
  logic [IDX_W-1:0] r_cand_idx;
  logic [SAD_W-1:0] r_cand_sad;

  // Even SAD is presented in the compare cycle, odd SAD the cycle after.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      r_cand_valid <= 1'b0;
      r_cand_idx   <= '0;
      r_cand_sad   <= '0;
    end else if (w_accept && w_last_pix) begin
      r_cand_valid <= 1'b1;
      r_cand_idx   <= IDX_W'({r_pair_cnt, 1'b0});
      r_cand_sad   <= w_sum_a;
    end else if (r_pair_rdy) begin
      r_cand_valid <= 1'b1;
      r_cand_idx   <= w_odd_idx;
      r_cand_sad   <= w_hold_b;
    end else begin
      r_cand_valid <= 1'b0;
    end
  end

  assign cand_valid = r_cand_valid;
  assign cand_idx   = r_cand_idx;
  assign cand_sad   = r_cand_sad;
`endif

endmodule

// File: tb/tb_sad_best_tracker.sv
// Directed bench for sad_best_tracker: hand-computed searches, gaps, abort
// and reset-mid-search, with a done-event scoreboard.
module tb_sad_best_tracker;
  localparam int PIX   = 256;
  localparam int PAIRS = 8;
  localparam int SW    = 16;
  localparam int IW    = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    c;
  logic [7:0]    p;
  logic [7:0]    p_prime;
  logic          busy;
  logic          done;
  logic [SW-1:0] best_sad;
  logic [IW-1:0] best_idx;
  logic [1:0]    dbg_state;
`ifdef SAD_CAND_OUT_EN
  logic          cand_valid;
  logic [IW-1:0] cand_idx;
  logic [SW-1:0] cand_sad;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [SW+IW-1:0] exp_q[$];

  sad_best_tracker #(.PIX_PER_CAND(PIX), .NUM_PAIRS(PAIRS), .SAD_W(SW), .IDX_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .c         (c),
    .p         (p),
    .p_prime   (p_prime),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_idx  (best_idx),
`ifdef SAD_CAND_OUT_EN
    .cand_valid(cand_valid),
    .cand_idx  (cand_idx),
    .cand_sad  (cand_sad),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      logic [SW+IW-1:0] e;
      done_cnt++;
      check("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_sad", 32'(best_sad), 32'(e[SW+IW-1:IW]));
        check("sb_idx", 32'(best_idx), 32'(e[IW-1:0]));
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    c        = 8'($urandom_range(0, 255));
    p        = 8'($urandom_range(0, 255));
    p_prime  = 8'($urandom_range(0, 255));
    step();
  endtask

  task automatic send_pix(input logic [7:0] cv, input logic [7:0] pv, input logic [7:0] ppv);
    in_valid = 1'b1;
    c        = cv;
    p        = pv;
    p_prime  = ppv;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // {c, p, p_prime} for a stimulus mode and pair number.
  function automatic logic [23:0] pix_of(input int mode, input int pair);
    case (mode)
      0:       return {8'h10, 8'h10, 8'h10};
      1:       return {8'h80, 8'h83, (pair == 2) ? 8'h81 : 8'h83};
      2:       return {8'hFF, 8'h00, 8'h00};
      default: return {8'hFF, (pair == 0) ? 8'h01 : 8'h00, 8'h00};
    endcase
  endfunction

  task automatic send_pixels(input int mode, input bit gaps, input int n);
    logic [23:0] v;
    for (int i = 0; i < n; i++) begin
      if (gaps)
        for (int g = 0; g < 6 && $urandom_range(0, 1) == 0; g++) idle_cycle();
      v = pix_of(mode, i / PIX);
      send_pix(v[23:16], v[15:8], v[7:0]);
    end
  endtask

  // Called right after the last pixel edge: done must rise exactly 2 cycles later.
  task automatic finish_search(input string tag, input logic [SW-1:0] e_sad, input logic [IW-1:0] e_idx);
    check({tag, "_t1_done"}, 32'(done), 32'd0);
    check({tag, "_t1_busy"}, 32'(busy), 32'd1);
    check({tag, "_t1_state"}, 32'(dbg_state), 32'd2);
    step();
    check({tag, "_t2_done"}, 32'(done), 32'd1);
    check({tag, "_t2_busy"}, 32'(busy), 32'd0);
    check({tag, "_sad"}, 32'(best_sad), 32'(e_sad));
    check({tag, "_idx"}, 32'(best_idx), 32'(e_idx));
    step();
    check({tag, "_t3_done"}, 32'(done), 32'd0);
    check({tag, "_t3_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic full_search(input string tag, input int mode, input bit gaps,
                             input logic [SW-1:0] e_sad, input logic [IW-1:0] e_idx);
    exp_q.push_back({e_sad, e_idx});
    do_start();
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    send_pixels(mode, gaps, PIX * PAIRS);
    finish_search(tag, e_sad, e_idx);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    c = '0; p = '0; p_prime = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sad", 32'(best_sad), 32'd0);
    check("rst_idx", 32'(best_idx), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    step();

    // Pixels offered in IDLE must be ignored.
    send_pixels(2, 1'b0, 20);
    check("idle_ignore_state", 32'(dbg_state), 32'd0);
    check("idle_ignore_busy", 32'(busy), 32'd0);

    full_search("ident", 0, 1'b0, 16'd0, 4'd0);
    full_search("uniq", 1, 1'b0, 16'd256, 4'd5);
    full_search("max", 2, 1'b0, 16'd65280, 4'd0);
    full_search("cand0", 3, 1'b0, 16'd65024, 4'd0);
    full_search("gaps", 1, 1'b1, 16'd256, 4'd5);

    // Abort mid pair 3, then a clean search; only the second result may appear.
    d0 = done_cnt;
    do_start();
    send_pixels(1, 1'b0, 3 * PIX + 128);
    exp_q.push_back({16'd65024, 4'd0});
    do_start();
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_keep_sad", 32'(best_sad), 32'd256);
    check("abort_keep_idx", 32'(best_idx), 32'd5);
    send_pixels(3, 1'b0, PIX * PAIRS);
    finish_search("abort", 16'd65024, 4'd0);
    check("abort_one_done", 32'(done_cnt - d0), 32'd1);

    // Reset during pair 4.
    do_start();
    send_pixels(2, 1'b0, 4 * PIX + 50);
    reset = 1'b1;
    step();
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_sad", 32'(best_sad), 32'd0);
    check("rstmid_idx", 32'(best_idx), 32'd0);
    check("rstmid_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    step();
    full_search("after_rst", 1, 1'b0, 16'd256, 4'd5);

    repeat (3) step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_best_tracker.md
Name: sad_best_tracker

Overview:
- Consumer end of the motion-estimation pixel stream. It receives per-cycle current pixel c and two reference candidate pixels p and p_prime, together with the start pulse, from the fetch/control block.
- Accumulates two sums of absolute differences (SADs) in parallel, one candidate per reference stream.
- Tracks the minimum SAD across all candidates of a search and reports the winning candidate index.
- Sits between the fetch controller and the motion-vector writeback logic.

Parameters:
- PIX_PER_CAND, 256, pixels per candidate block (16x16); must be a power of two.
- NUM_PAIRS, 8, candidate pairs per search; total candidates = 2*NUM_PAIRS.
- SAD_W, 16, SAD width; must hold PIX_PER_CAND*255 (65280 fits in 16 bits).
- IDX_W, 4, candidate index width, equal to log2(2*NUM_PAIRS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a new search
- in_valid  in  1  c/p/p_prime valid this cycle
- c  in  8  current-block pixel
- p  in  8  reference pixel, even candidate (2k)
- p_prime  in  8  reference pixel, odd candidate (2k+1)
- busy  out  1  search in progress
- done  out  1  one-cycle pulse; result valid
- best_sad  out  SAD_W  minimum SAD of the last completed search
- best_idx  out  IDX_W  index of the candidate with that minimum

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset values: state IDLE; busy=0; done=0; best_sad=0; best_idx=0; all accumulators, counters and hold registers 0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: last pixel of last pair accepted -> FINAL.
  - FINAL: -> DONE.
  - DONE: -> IDLE.
- busy=1 in RUN and FINAL.
- start, on entering RUN:
  - pix_cnt=0, pair_cnt=0, both accumulators 0.
  - Running minimum set to all-ones; running index set to 0.
  - best_sad/best_idx are not touched until DONE.
- in_valid in RUN:
  - diff_a=|c-p| and diff_b=|c-p_prime|, computed as 9-bit signed subtraction with absolute value, result 8 bits.
  - acc_a+=diff_a and acc_b+=diff_b, zero-extended to SAD_W; no overflow is possible by parameter constraint.
  - pix_cnt increments and wraps at PIX_PER_CAND.
- in_valid low in RUN: all counters and accumulators hold; gaps of any length are legal.
- Last pixel of a pair (pix_cnt==PIX_PER_CAND-1 with in_valid):
  - hold_a<=acc_a+diff_a, hold_b<=acc_b+diff_b, pair_rdy<=1.
  - acc_a, acc_b <= 0.
  - pair_cnt increments.
  - The next pair's first pixel is accepted in the very next cycle; there is no stall and no ready signal.
- Compare stage (cycle with pair_rdy=1), evaluated in order:
  - hold_a < running minimum: update minimum and index to 2*pair.
  - Then hold_b < updated minimum: update to 2*pair+1.
  - Strict less-than, so ties keep the lower index.
  - pair_rdy clears.
- Latency: last pixel accepted at cycle T; compare at T+1 (FINAL); best_sad/best_idx registered and done=1 during T+2 (DONE).
- start while busy: abort the current search, restart cleanly; no done is emitted for the aborted search.
- start in DONE: accepted; done still pulses this cycle, next state is RUN.
- in_valid while in IDLE, FINAL or DONE: ignored.
- reset mid-search: immediate return to the reset values; best_sad/best_idx cleared.

Optional Feature:
- Macro: SAD_CAND_OUT_EN.
- When defined, adds outputs cand_valid (1), cand_idx (IDX_W) and cand_sad (SAD_W). These emit both candidate SADs of each pair on two consecutive cycles: even in the compare cycle, odd in the cycle after, used for debug/trace.
- Because pairs are at least PIX_PER_CAND cycles apart, the two emissions never collide.
- When not defined, the ports and their registers are absent; core behaviour is identical.

Decomposition:
- Shared package me_pkg:
  - PIX_W=8, the default for SAD_W, and a helper function that derives IDX_W.
  - State enum {IDLE,RUN,FINAL,DONE}.
- One natural sub-module: sad_accum, instantiated twice (a/b). Contents:
  - abs-diff, accumulator, clear-on-last and hold register.
- The top module holds the FSM, counters and comparator.

Test Plan:
- Identical streams: c=p=p_prime=0x10 for all pixels, NUM_PAIRS=8 -> best_sad=0, best_idx=0 (tie rule); done exactly 2 cycles after the last in_valid.
- Unique minimum: candidate 5 (pair 2, p_prime) has diff 1 per pixel, all others diff 3 -> best_sad=256, best_idx=5.
- Max values: c=0xFF, p=0x00, all candidates -> best_sad=65280, no wrap; candidate 0 with diff 254 -> best_idx=0, best_sad=65024.
- in_valid toggled randomly at 50% with the unique-minimum stimulus -> same results as the continuous run; done occurs 2 cycles after the final accepted pixel.
- start reasserted mid pair 3, then a full clean search -> exactly one done, result matches the second search only.
- reset asserted during pair 4 -> busy=0, best_sad=0, best_idx=0 next cycle; a subsequent search gives correct results.
